// File: rtl/urisc_pkg.sv
// urisc_pkg -- shared types and constants for the subtract-and-branch-if-negative core. Rev 1.0
`default_nettype none

package urisc_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] word_t;

  localparam word_t START_PC = 8'h01;
  localparam word_t HALT_PC  = 8'h00;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_A  = 3'd1,
    FETCH_B  = 3'd2,
    FETCH_C  = 3'd3,
    READ_OPA = 3'd4,
    READ_OPB = 3'd5,
    WRITE_B  = 3'd6,
    HALT     = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/urisc_alu.sv
// urisc_alu -- combinational 8-bit subtract with sign flag for the urisc core. Rev 1.0
`default_nettype none

module urisc_alu
  import urisc_pkg::*;
(
  input  logic [DATA_W-1:0] minuend,
  input  logic [DATA_W-1:0] subtrahend,
  output logic [DATA_W-1:0] diff,
  output logic              neg
);

  assign diff = minuend - subtrahend;
  assign neg  = diff[DATA_W-1];

endmodule

`default_nettype wire

// File: rtl/urisc_core.sv
// urisc_core -- single-instruction (subleq-style) processor driving a 128x8 RAM. Rev 1.0
// Optional instruction counter output enabled by defining URISC_ICOUNT_EN.
`default_nettype none

module urisc_core
  import urisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              CS,
  output logic              READ,
  output logic              WRITE,
  output logic [DATA_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W-1:0] RDATA,
  output logic              halted
`ifdef URISC_ICOUNT_EN
  ,
  output logic [15:0]       icount
`endif
);

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   a_addr;
  logic [DATA_W-1:0]   b_addr;
  logic [DATA_W-1:0]   c_addr;
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   diff_q;
  logic                neg_q;
  logic [DATA_W-1:0]   alu_diff;
  logic                alu_neg;
  logic [DATA_W-1:0]   pc_p1;
  logic [DATA_W-1:0]   pc_p2;
  logic [DATA_W-1:0]   pc_p3;

  assign pc_p1 = pc + 8'd1;
  assign pc_p2 = pc + 8'd2;
  assign pc_p3 = pc + 8'd3;

  // Operand B arrives on RDATA in READ_OPB; operand A was latched the cycle before.
  urisc_alu u_alu (
    .minuend    (RDATA),
    .subtrahend (opa),
    .diff       (alu_diff),
    .neg        (alu_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = FETCH_A;
      FETCH_A:  state_next = (pc == HALT_PC) ? HALT : FETCH_B;
      FETCH_B:  state_next = FETCH_C;
      FETCH_C:  state_next = READ_OPA;
      READ_OPA: state_next = READ_OPB;
      READ_OPB: state_next = WRITE_B;
      WRITE_B:  state_next = FETCH_A;
      HALT:     state_next = HALT;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= START_PC;
      a_addr <= '0;
      b_addr <= '0;
      c_addr <= '0;
      opa    <= '0;
      diff_q <= '0;
      neg_q  <= 1'b0;
    end else begin
      case (state)
        FETCH_A:  a_addr <= RDATA;
        FETCH_B:  b_addr <= RDATA;
        FETCH_C:  c_addr <= RDATA;
        READ_OPA: opa    <= RDATA;
        READ_OPB: begin
          diff_q <= alu_diff;
          neg_q  <= alu_neg;
        end
        WRITE_B:  pc <= neg_q ? c_addr : pc_p3;
        default: ;
      endcase
    end
  end

  // Moore output decode; the halt-marker read at PC==0 is still a real RAM read.
  always_comb begin
    READ    = 1'b0;
    WRITE   = 1'b0;
    ADDRESS = '0;
    WDATA   = '0;
    case (state)
      FETCH_A: begin
        READ    = 1'b1;
        ADDRESS = pc;
      end
      FETCH_B: begin
        READ    = 1'b1;
        ADDRESS = pc_p1;
      end
      FETCH_C: begin
        READ    = 1'b1;
        ADDRESS = pc_p2;
      end
      READ_OPA: begin
        READ    = 1'b1;
        ADDRESS = a_addr;
      end
      READ_OPB: begin
        READ    = 1'b1;
        ADDRESS = b_addr;
      end
      WRITE_B: begin
        WRITE   = 1'b1;
        ADDRESS = b_addr;
        WDATA   = diff_q;
      end
      default: ;
    endcase
  end

  assign CS     = READ | WRITE;
  assign halted = (state == HALT);

`ifdef URISC_ICOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icount <= 16'h0000;
    end else if ((state == WRITE_B) && (icount != 16'hFFFF)) begin
      icount <= icount + 16'h0001;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_urisc_core.sv
// tb_urisc_core -- directed self-checking bench for urisc_core with a behavioural RAM.
`default_nettype none

module tb_urisc_core;

  logic       clk;
  logic       rst_n;
  logic       CS;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WDATA;
  logic [7:0] RDATA;
  logic       halted;
`ifdef URISC_ICOUNT_EN
  logic [15:0] icount;
`endif

  logic [7:0] mem [0:255];
  logic [7:0] img [0:255];
  logic       do_load;

  int n_tests;
  int n_fail;

  urisc_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .CS      (CS),
    .READ    (READ),
    .WRITE   (WRITE),
    .ADDRESS (ADDRESS),
    .WDATA   (WDATA),
    .RDATA   (RDATA),
    .halted  (halted)
`ifdef URISC_ICOUNT_EN
    ,
    .icount  (icount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write captured at the edge ending a WRITE cycle.
  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (CS && WRITE) begin
      mem[ADDRESS] <= WDATA;
    end
  end

  assign RDATA = mem[ADDRESS];

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic start_run();
    rst_n   = 1'b0;
    do_load = 1'b1;
    @(posedge clk);
    #1;
    do_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_img();
    img[1] = 8'd40; img[2] = 8'd31; img[3] = 8'd4; img[40] = 8'd100;
    rst_n   = 1'b0;
    do_load = 1'b1;
    @(posedge clk);
    #1;
    do_load = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({CS, READ, WRITE, halted} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 0000", {CS, READ, WRITE, halted});
    end
    n_tests++;
    if (ADDRESS !== 8'h00 || WDATA !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h wdata=%h required 00/00", ADDRESS, WDATA);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({CS, READ, WRITE} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_release: got %b required 000", {CS, READ, WRITE});
    end
    @(negedge clk);
    n_tests++;
    if ({CS, READ, WRITE} !== 3'b110 || ADDRESS !== 8'd1) begin
      n_fail++;
      $display("FAIL first_fetch: got strobes=%b addr=%0d required 110/1", {CS, READ, WRITE}, ADDRESS);
    end
  endtask

  task automatic test_branch_taken();
    clear_img();
    img[1] = 8'd40; img[2] = 8'd31; img[3] = 8'd4; img[40] = 8'd100; img[31] = 8'd0;
    start_run();
    step(5);
    n_tests++;
    if ({CS, READ, WRITE} !== 3'b110 || ADDRESS !== 8'd31) begin
      n_fail++;
      $display("FAIL taken_read_b: got strobes=%b addr=%0d required 110/31", {CS, READ, WRITE}, ADDRESS);
    end
    step(1);
    n_tests++;
    if ({CS, READ, WRITE} !== 3'b101 || ADDRESS !== 8'd31 || WDATA !== 8'h9C) begin
      n_fail++;
      $display("FAIL taken_write: got strobes=%b addr=%0d wdata=%h required 101/31/9c",
               {CS, READ, WRITE}, ADDRESS, WDATA);
    end
    step(1);
    n_tests++;
    if ({CS, READ, WRITE} !== 3'b110 || ADDRESS !== 8'd4 || mem[31] !== 8'h9C) begin
      n_fail++;
      $display("FAIL taken_next_fetch: got addr=%0d mem31=%h required 4/9c", ADDRESS, mem[31]);
    end
  endtask

  task automatic test_no_branch();
    logic [7:0] b_loc [0:2];
    logic [7:0] va    [0:2];
    logic [7:0] vb    [0:2];
    logic [7:0] res   [0:2];
    b_loc[0] = 8'd51; va[0] = 8'd1; vb[0] = 8'd5; res[0] = 8'd4;
    b_loc[1] = 8'd51; va[1] = 8'd7; vb[1] = 8'd7; res[1] = 8'd0;
    b_loc[2] = 8'd50; va[2] = 8'd7; vb[2] = 8'd7; res[2] = 8'd0;
    for (int v = 0; v < 3; v++) begin
      clear_img();
      img[1] = 8'd50; img[2] = b_loc[v]; img[3] = 8'd9;
      img[50] = va[v];
      if (b_loc[v] != 8'd50) img[b_loc[v]] = vb[v];
      start_run();
      step(6);
      n_tests++;
      if (WRITE !== 1'b1 || ADDRESS !== b_loc[v] || WDATA !== res[v]) begin
        n_fail++;
        $display("FAIL nobranch_write_%0d: got wr=%b addr=%0d wdata=%h required 1/%0d/%h",
                 v, WRITE, ADDRESS, WDATA, b_loc[v], res[v]);
      end
      step(1);
      n_tests++;
      if (READ !== 1'b1 || ADDRESS !== 8'd4 || mem[b_loc[v]] !== res[v]) begin
        n_fail++;
        $display("FAIL nobranch_next_%0d: got addr=%0d mem=%h required 4/%h",
                 v, ADDRESS, mem[b_loc[v]], res[v]);
      end
    end
  endtask

  task automatic test_program();
    int rd0;
    int post;
    clear_img();
    // T -= X; T -= Y; loop { Q -= -1; T -= -2 while T<0 }; Z -= X -> jump to 0
    img[1]  = 8'd32; img[2]  = 8'd38; img[3]  = 8'd4;
    img[4]  = 8'd33; img[5]  = 8'd38; img[6]  = 8'd7;
    img[7]  = 8'd37; img[8]  = 8'd36; img[9]  = 8'd10;
    img[10] = 8'd35; img[11] = 8'd38; img[12] = 8'd7;
    img[13] = 8'd32; img[14] = 8'd34; img[15] = 8'd0;
    img[32] = 8'd16; img[33] = 8'd100; img[34] = 8'd0;
    img[35] = 8'hFE; img[36] = 8'd0;   img[37] = 8'hFF; img[38] = 8'd0;
    start_run();
    rd0  = 0;
    post = 0;
    for (int k = 0; k < 2000 && !halted; k++) begin
      @(negedge clk);
      if (CS && READ && ADDRESS == 8'd0) rd0++;
    end
    n_tests++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL prog_halted: got %b required 1 within budget", halted);
    end
    n_tests++;
    if (mem[36] !== 8'h3A) begin
      n_fail++;
      $display("FAIL prog_result: got %h required 3a", mem[36]);
    end
    n_tests++;
    if (rd0 != 1) begin
      n_fail++;
      $display("FAIL prog_addr0_reads: got %0d required 1", rd0);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (CS || READ || WRITE || !halted) post++;
    end
    n_tests++;
    if (post != 0) begin
      n_fail++;
      $display("FAIL prog_after_halt: got %0d active cycles required 0", post);
    end
`ifdef URISC_ICOUNT_EN
    n_tests++;
    if (icount !== 16'd119) begin
      n_fail++;
      $display("FAIL prog_icount: got %0d required 119", icount);
    end
`endif
  endtask

  task automatic test_reset_in_write();
    clear_img();
    img[1] = 8'd40; img[2] = 8'd31; img[3] = 8'd4; img[40] = 8'd100;
    start_run();
    step(6);
    n_tests++;
    if (WRITE !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwr_pre: got write=%b required 1", WRITE);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({CS, READ, WRITE} !== 3'b000 || ADDRESS !== 8'h00 || WDATA !== 8'h00) begin
      n_fail++;
      $display("FAIL rstwr_drop: got strobes=%b addr=%h wdata=%h required 000/00/00",
               {CS, READ, WRITE}, ADDRESS, WDATA);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (mem[31] !== 8'h00) begin
      n_fail++;
      $display("FAIL rstwr_abandon: got mem31=%h required 00", mem[31]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({CS, READ, WRITE} !== 3'b110 || ADDRESS !== 8'd1) begin
      n_fail++;
      $display("FAIL rstwr_refetch: got strobes=%b addr=%0d required 110/1", {CS, READ, WRITE}, ADDRESS);
    end
  endtask

  task automatic test_pc_wrap();
    logic [7:0] exp_addr [0:4];
    exp_addr[0] = 8'd254; exp_addr[1] = 8'd255; exp_addr[2] = 8'd0;
    exp_addr[3] = 8'd50;  exp_addr[4] = 8'd51;
    clear_img();
    img[1] = 8'd40; img[2] = 8'd31; img[3] = 8'd254; img[40] = 8'd100;
    img[254] = 8'd50; img[255] = 8'd51; img[0] = 8'd0;
    img[50] = 8'd1; img[51] = 8'd0;
    start_run();
    step(6);
    for (int k = 0; k < 5; k++) begin
      step(1);
      n_tests++;
      if (READ !== 1'b1 || ADDRESS !== exp_addr[k] || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_read_%0d: got rd=%b addr=%0d halted=%b required 1/%0d/0",
                 k, READ, ADDRESS, halted, exp_addr[k]);
      end
    end
    step(1);
    n_tests++;
    if (WRITE !== 1'b1 || ADDRESS !== 8'd51 || WDATA !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_write: got wr=%b addr=%0d wdata=%h required 1/51/ff", WRITE, ADDRESS, WDATA);
    end
    step(1);
    n_tests++;
    if (READ !== 1'b1 || ADDRESS !== 8'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_halt_fetch: got rd=%b addr=%0d halted=%b required 1/0/0", READ, ADDRESS, halted);
    end
    step(1);
    n_tests++;
    if (halted !== 1'b1 || {CS, READ, WRITE} !== 3'b000) begin
      n_fail++;
      $display("FAIL wrap_halted: got halted=%b strobes=%b required 1/000", halted, {CS, READ, WRITE});
    end
`ifdef URISC_ICOUNT_EN
    n_tests++;
    if (icount !== 16'd2) begin
      n_fail++;
      $display("FAIL wrap_icount: got %0d required 2", icount);
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    do_load = 1'b0;
    test_reset();
    test_branch_taken();
    test_no_branch();
    test_program();
    test_reset_in_write();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/urisc_core.md
# urisc_core

Single-instruction (subtract-and-branch-if-negative) processor core that sits directly upstream of the 128×8 program/data RAM and is its only master. It drives the RAM strobes and address each cycle, consumes the combinational read data, executes the program loaded in RAM at reset starting at address 1, and halts when control transfers to address 0.

## Interface
- No parameters; widths are fixed at 8 bits (`urisc_pkg`).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `CS` output 1: RAM chip select.
- `READ` output 1: RAM read strobe; `RDATA` is valid in the same cycle.
- `WRITE` output 1: RAM write strobe; the RAM captures `WDATA` at the rising edge that ends the cycle.
- `ADDRESS` output 8: RAM address.
- `WDATA` output 8: RAM write data.
- `RDATA` input 8: RAM read data, combinational from `ADDRESS`.
- `halted` output 1: high once the core has stopped.

## Operation
- Instruction: three consecutive bytes A, B, C at PC, PC+1, PC+2.
- Semantics: mem[B] ← mem[B] − mem[A], using 8-bit two's-complement arithmetic with the result truncated to 8 bits. If the result bit 7 is 1, PC ← C; otherwise PC ← PC+3. All PC arithmetic wraps modulo 256.
- A result of 0 does not branch.
- FSM states and transitions:
  - IDLE → FETCH_A.
  - FETCH_A: read at PC, latch A. If PC==0 the read is still issued (the RAM uses the read of address 0 as its end-of-run marker) and the next state is HALT; otherwise → FETCH_B.
  - FETCH_B: read at PC+1, latch B → FETCH_C.
  - FETCH_C: read at PC+2, latch C → READ_OPA.
  - READ_OPA: read at A, latch operand → READ_OPB.
  - READ_OPB: read at B, compute and latch diff and neg → WRITE_B.
  - WRITE_B: CS=1, WRITE=1, ADDRESS=B, WDATA=diff; update PC → FETCH_A.
  - HALT: terminal; the core leaves it only on reset.
- Outputs are a Moore decode of the registered state and the A/B/PC registers. READ and WRITE are never both high. CS is high exactly when READ or WRITE is high.
- `halted` goes high in the first cycle of HALT and holds.
- Out-of-range addresses (128 and above) are issued unchanged; their handling is the RAM's concern.

## Timing
- Reset values: CS=READ=WRITE=0, ADDRESS=0, WDATA=0, halted=0, PC=8'h01, state=IDLE. All are forced immediately on `rst_n` falling, including mid-instruction; an interrupted write is abandoned.
- The first fetch, at ADDRESS=1, occurs in the 2nd cycle after `rst_n` rises.
- Each instruction takes exactly 6 cycles. The next FETCH_A follows WRITE_B with no gap.
- A write to B is visible to any later read, including a fetch, because the RAM updates at the WRITE_B edge.
- A == B is legal: the result is 0, no branch.
- The halt sequence is one FETCH_A read at address 0 followed by HALT with all strobes low.

## Configuration
- `URISC_ICOUNT_EN` defined:
  - Adds output `icount` [15:0], reset value 0.
  - `icount` increments once per completed WRITE_B and saturates at 16'hFFFF.
- `URISC_ICOUNT_EN` undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- `urisc_pkg` holds:
  - the state enum (IDLE, FETCH_A, FETCH_B, FETCH_C, READ_OPA, READ_OPB, WRITE_B, HALT);
  - `START_PC` = 8'h01 and `HALT_PC` = 8'h00;
  - the data width (8).
- One sub-module, `urisc_alu`: combinational 8-bit subtract producing diff[7:0] and neg (= diff[7]). The FSM, PC and latches stay in `urisc_core`.

## Test plan
1. Reset and release:
   - During reset, all outputs are 0.
   - The cycle after release is IDLE with strobes low.
   - The next cycle shows CS=READ=1, ADDRESS=1.
2. Branch taken: mem[1..3]={40,31,4}, mem[40]=100, mem[31]=0.
   - A write of 0x9C to 31 occurs in cycle 6 of the instruction.
   - The next fetch is at ADDRESS=4.
3. No branch: mem[1..3]={50,51,9}, mem[50]=1, mem[51]=5.
   - mem[51] becomes 4 and the next fetch is at 4 (PC+3).
   - A variant with mem[50]=mem[51]=7 gives 0 and no branch.
4. Full (X+Y)/2 program with X=16, Y=100:
   - The core halts with mem[36]=58 (0x3A) and `halted`=1.
   - Exactly one read of ADDRESS=0 occurs, then no further strobes.
5. Reset asserted in WRITE_B:
   - WRITE drops in the same cycle.
   - After release the core fetches from ADDRESS=1 again.
6. PC wrap: branch to C=254.
   - Fetches occur at 254, 255, 0 (as FETCH_C, not a halt).
   - With `URISC_ICOUNT_EN` defined, `icount` equals the retired-instruction count at halt.
